nebula_axil_arbiter: RTL

- Shares one AXI-lite config register slave (cfg regs, QoS threshold / cluster ID) among N_MASTERS requesters, e.g. host bridge, management core and debug port.
- Each requester issues one combined transaction: a write (addr + data + strb) or a read (addr).
- Round-robin grant; one transaction in flight at a time.
- Per-transaction timeout returns SLVERR to the requester so a hung slave cannot lock up the others.

---
 rtl/nebula_axil_arbiter.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/nebula_axil_arbiter.sv
`default_nettype none
// ==== nebula_axil_arbiter : round-robin N-master arbiter onto one AXI-lite style config slave ====
// ==== rev 1.0 : initial release                                                               ====
module nebula_axil_arbiter #(
  parameter int N_MASTERS   = 3,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_MASTERS-1:0]          m_req_valid,
  input  logic [N_MASTERS-1:0]          m_req_write,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_req_addr,
  input  logic [N_MASTERS*32-1:0]       m_req_wdata,
  input  logic [N_MASTERS*4-1:0]        m_req_wstrb,
  output logic [N_MASTERS-1:0]          m_req_ready,
  output logic [N_MASTERS-1:0]          m_rsp_valid,
  output logic [31:0]                   m_rsp_rdata,
  output logic [1:0]                    m_rsp_resp,
  input  logic [N_MASTERS-1:0]          m_rsp_ready,
  output logic                          s_req_valid,
  output logic                          s_req_write,
  output logic [ADDR_W-1:0]             s_req_addr,
  output logic [31:0]                   s_req_wdata,
  output logic [3:0]                    s_req_wstrb,
  input  logic                          s_req_ready,
  input  logic                          s_rsp_valid,
  input  logic [31:0]                   s_rsp_rdata,
  input  logic [1:0]                    s_rsp_resp,
  output logic                          s_rsp_ready,
  output logic                          busy,
  output logic [2:0]                    grant_id,
  output logic [15:0]                   timeout_cnt
);

  localparam int                 C_PTR_W    = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int                 C_TMR_W    = $clog2(TIMEOUT_CYC);
  localparam logic [C_TMR_W-1:0] C_TMR_LAST = C_TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [C_PTR_W-1:0] C_M_LAST   = C_PTR_W'(N_MASTERS - 1);
  localparam logic [C_PTR_W:0]   C_M_NUM    = (C_PTR_W + 1)'(N_MASTERS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [ADDR_W-1:0]    w_addr_arr  [N_MASTERS];
  logic [31:0]          w_wdata_arr [N_MASTERS];
  logic [3:0]           w_wstrb_arr [N_MASTERS];

  logic [C_PTR_W-1:0]   r_rr_ptr;
  logic [C_PTR_W-1:0]   r_gnt;
  logic [C_PTR_W-1:0]   w_sel;
  logic [C_PTR_W:0]     w_idx_sum;
  logic [C_PTR_W-1:0]   w_idx;
  logic                 w_found;
  logic                 w_accept;
  logic                 w_cap_slave;
  logic                 w_cap_timeout;
  logic                 w_tmr_hit;

  logic [C_TMR_W-1:0]   r_tmr;
  logic                 r_req_write;
  logic [ADDR_W-1:0]    r_req_addr;
  logic [31:0]          r_req_wdata;
  logic [3:0]           r_req_wstrb;
  logic [31:0]          r_rsp_rdata;
  logic [1:0]           r_rsp_resp;
  logic [15:0]          r_to_cnt;

  for (genvar g = 0; g < N_MASTERS; g++) begin : g_unpack
    assign w_addr_arr[g]  = m_req_addr[g*ADDR_W +: ADDR_W];
    assign w_wdata_arr[g] = m_req_wdata[g*32 +: 32];
    assign w_wstrb_arr[g] = m_req_wstrb[g*4 +: 4];
  end

  // First valid requester at or above the pointer, wrapping at N_MASTERS
  always_comb begin
    w_found   = 1'b0;
    w_sel     = '0;
    w_idx_sum = '0;
    w_idx     = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      w_idx_sum = {1'b0, r_rr_ptr} + (C_PTR_W + 1)'(k);
      if (w_idx_sum >= C_M_NUM) begin
        w_idx_sum = w_idx_sum - C_M_NUM;
      end
      w_idx = w_idx_sum[C_PTR_W-1:0];
      if (!w_found && m_req_valid[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  assign w_tmr_hit = (r_tmr == C_TMR_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_cap_slave   = 1'b0;
    w_cap_timeout = 1'b0;
    m_req_ready   = '0;
    m_rsp_valid   = '0;
    s_req_valid   = 1'b0;
    s_rsp_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        // Gated by rst_n so the accept pulse is also silent while reset is held
        if (w_found && rst_n) begin
          w_accept           = 1'b1;
          m_req_ready[w_sel] = 1'b1;
          w_state_nxt        = ISSUE;
        end
      end
      ISSUE: begin
        s_req_valid = 1'b1;
        s_rsp_ready = 1'b1;
        if (s_req_ready && s_rsp_valid) begin
          w_cap_slave = 1'b1;
          w_state_nxt = RESP;
        end else if (w_tmr_hit) begin
          w_cap_timeout = 1'b1;
          w_state_nxt   = RESP;
        end else if (s_req_ready) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        s_rsp_ready = 1'b1;
        if (s_rsp_valid) begin
          w_cap_slave = 1'b1;
          w_state_nxt = RESP;
        end else if (w_tmr_hit) begin
          w_cap_timeout = 1'b1;
          w_state_nxt   = RESP;
        end
      end
      RESP: begin
        m_rsp_valid[r_gnt] = 1'b1;
        if (m_rsp_ready[r_gnt]) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_gnt       <= '0;
      r_tmr       <= '0;
      r_req_write <= 1'b0;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
      r_req_wstrb <= '0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= '0;
      r_to_cnt    <= '0;
    end else begin
      if (w_accept) begin
        r_rr_ptr    <= (w_sel == C_M_LAST) ? '0 : w_sel + 1'b1;
        r_gnt       <= w_sel;
        r_tmr       <= '0;
        r_req_write <= m_req_write[w_sel];
        r_req_addr  <= w_addr_arr[w_sel];
        r_req_wdata <= w_wdata_arr[w_sel];
        r_req_wstrb <= w_wstrb_arr[w_sel];
      end else if (r_state == ISSUE || r_state == WAIT) begin
        r_tmr <= r_tmr + 1'b1;
      end
      if (w_cap_slave) begin
        r_rsp_rdata <= s_rsp_rdata;
        r_rsp_resp  <= s_rsp_resp;
      end else if (w_cap_timeout) begin
        r_rsp_rdata <= '0;
        r_rsp_resp  <= 2'b10;
        if (r_to_cnt != 16'hFFFF) begin
          r_to_cnt <= r_to_cnt + 16'd1;
        end
      end
    end
  end

  assign s_req_write = r_req_write;
  assign s_req_addr  = r_req_addr;
  assign s_req_wdata = r_req_wdata;
  assign s_req_wstrb = r_req_wstrb;
  assign m_rsp_rdata = r_rsp_rdata;
  assign m_rsp_resp  = r_rsp_resp;
  assign busy        = (r_state != IDLE);
  assign grant_id    = 3'(r_gnt);
  assign timeout_cnt = r_to_cnt;

endmodule
`default_nettype wire
